// File: rtl/sine_pwm_dds.sv
// Multi-channel DDS sine-PWM generator with a 5-byte UART command parser (A5, chan, tw[23:16], tw[15:8], tw[7:0]).
// PWM outputs registered one cycle after cnt; command bytes are never back-pressured, ack/err pulse one cycle after the last byte.
module sine_pwm_dds #(
    parameter int CHANNELS      = 2,
    parameter int PWM_BITS      = 8,
    parameter int ACC_BITS      = 24,
    parameter int LUT_ADDR_BITS = 8
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                enable,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                cmd_ack,
    output logic                cmd_err
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR_BITS;

    function automatic logic [PWM_BITS-1:0] lut_entry(input int k);
        real amp;
        real s;
        int  r;
        amp = real'((1 << (PWM_BITS - 1)) - 1);
        s   = amp * $sin(2.0 * 3.14159265358979 * real'(k) / real'(LUT_DEPTH));
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(-s + 0.5);
        return PWM_BITS'((1 << (PWM_BITS - 1)) + r);
    endfunction

    localparam logic [PWM_BITS-1:0] DUTY_RST = lut_entry(0);

    logic [PWM_BITS-1:0] lut [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam logic [PWM_BITS-1:0] LUT_V = lut_entry(k);
        assign lut[k] = LUT_V;
    end

    typedef enum logic [2:0] {IDLE, CHAN, W2, W1, W0} state_t;

    state_t     state_q;
    logic [7:0] chan_q;
    logic [7:0] w2_q;
    logic [7:0] w1_q;
    logic       cmd_ack_q;
    logic       cmd_err_q;

    logic                frame_done;
    logic                chan_ok;
    logic [23:0]         word_full;
    logic [ACC_BITS-1:0] new_word;

    assign frame_done = cmd_valid && (state_q == W0);
    assign chan_ok    = int'(chan_q) < CHANNELS;
    assign word_full  = {w2_q, w1_q, cmd_data};
    assign new_word   = word_full[ACC_BITS-1:0];

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            w2_q      <= '0;
            w1_q      <= '0;
            cmd_ack_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_ack_q <= 1'b0;
            cmd_err_q <= 1'b0;
            if (cmd_valid) begin
                case (state_q)
                    IDLE: if (cmd_data == 8'hA5) state_q <= CHAN;
                    CHAN: begin
                        chan_q  <= cmd_data;
                        state_q <= W2;
                    end
                    W2: begin
                        w2_q    <= cmd_data;
                        state_q <= W1;
                    end
                    W1: begin
                        w1_q    <= cmd_data;
                        state_q <= W0;
                    end
                    W0: begin
                        state_q   <= IDLE;
                        cmd_ack_q <= chan_ok;
                        cmd_err_q <= !chan_ok;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [ACC_BITS-1:0] acc_q [CHANNELS];
    logic [ACC_BITS-1:0] acc_d [CHANNELS];
    logic [ACC_BITS-1:0] tw_active_q [CHANNELS];
    logic [ACC_BITS-1:0] tw_active_d [CHANNELS];
    logic [ACC_BITS-1:0] tw_shadow_q [CHANNELS];
    logic [ACC_BITS-1:0] tw_shadow_d [CHANNELS];
    logic [PWM_BITS-1:0] duty_q [CHANNELS];
    logic [PWM_BITS-1:0] duty_d [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                boundary;

    assign boundary = enable && (cnt_q == '1);

    always_comb begin
        logic [ACC_BITS-1:0] nacc;
        cnt_d     = enable ? cnt_q + 1'b1 : cnt_q;
        pending_d = pending_q;
        pwm_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            nacc           = acc_q[i] + tw_active_q[i];
            acc_d[i]       = acc_q[i];
            tw_active_d[i] = tw_active_q[i];
            tw_shadow_d[i] = tw_shadow_q[i];
            duty_d[i]      = duty_q[i];
            pwm_d[i]       = enable && (cnt_q < duty_q[i]);
            // The phase step uses the old word; a swapped-in word only counts from the next boundary.
            if (boundary) begin
                acc_d[i]  = nacc;
                duty_d[i] = lut[nacc[ACC_BITS-1 -: LUT_ADDR_BITS]];
                if (pending_q[i]) begin
                    tw_active_d[i] = tw_shadow_q[i];
                    pending_d[i]   = 1'b0;
                end
            end
            // A write landing on a boundary re-arms pending, so it waits for the following boundary.
            if (frame_done && chan_ok && (int'(chan_q) == i)) begin
                tw_shadow_d[i] = new_word;
                pending_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= '0;
            pwm_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i]       <= '0;
                tw_active_q[i] <= '0;
                tw_shadow_q[i] <= '0;
                duty_q[i]      <= DUTY_RST;
            end
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i]       <= acc_d[i];
                tw_active_q[i] <= tw_active_d[i];
                tw_shadow_q[i] <= tw_shadow_d[i];
                duty_q[i]      <= duty_d[i];
            end
        end
    end

    assign pwm_out = pwm_q;
    assign cmd_ack = cmd_ack_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: doc/sine_pwm_dds.md
SINE_PWM_DDS -- requirements
Module: sine_pwm_dds

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning the number of independent sine-PWM channels (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning the PWM counter width and the sine sample width.
REQ-003 SHALL have parameter ACC_BITS, default 24, meaning the phase accumulator and tuning word width (16..24).
REQ-004 SHALL have parameter LUT_ADDR_BITS, default 8, meaning log2 of the sine table depth (at most ACC_BITS).
REQ-005 SHALL have port clk1, input, width 1: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, width 1: run/hold control.
REQ-008 SHALL have port cmd_valid, input, width 1: one-cycle strobe qualifying cmd_data (a UART rx_valid).
REQ-009 SHALL have port cmd_data, input, width 8: command byte.
REQ-010 SHALL have port pwm_out, output, width CHANNELS: registered PWM outputs.
REQ-011 SHALL have port cmd_ack, output, width 1: one-cycle pulse when a valid frame is accepted.
REQ-012 SHALL have port cmd_err, output, width 1: one-cycle pulse when a frame is rejected.

Function
REQ-013 SHALL run a free-running PWM_BITS counter cnt, 0..2^PWM_BITS-1, wrapping to 0; a "boundary" is a cycle with cnt at its maximum while enable=1.
REQ-014 SHALL keep per channel: acc[ACC_BITS], tw_active[ACC_BITS], tw_shadow[ACC_BITS], a pending flag, and duty[PWM_BITS].
REQ-015 SHALL, at each boundary and per channel, compute nacc = acc + tw_active modulo 2^ACC_BITS, set acc <= nacc, and set duty <= LUT[nacc[ACC_BITS-1 -: LUT_ADDR_BITS]].
REQ-016 SHALL, at each boundary and per channel with pending=1, set tw_active <= tw_shadow and clear pending; the new word takes effect from the following boundary.
REQ-017 SHALL define LUT[k] = 2^(PWM_BITS-1) + round((2^(PWM_BITS-1)-1) * sin(2*pi*k/2^LUT_ADDR_BITS)); at defaults LUT[0]=128, LUT[64]=255, LUT[128]=128, LUT[192]=1.
REQ-018 SHALL register pwm_out[i] <= (cnt < duty[i]) every cycle while enable=1, so duty 0 gives constant 0 and duty 255 gives 255 high cycles out of 256.
REQ-019 SHALL, while enable=0, hold cnt, all acc and all duty, and drive pwm_out to all zeros on the next cycle; the command parser keeps running.
REQ-020 SHALL parse a 5-byte frame: 0xA5, channel index, then tuning word bytes MSB first (bits 23:16, 15:8, 7:0, truncated to ACC_BITS).
REQ-021 SHALL implement the parser as FSM states IDLE, CHAN, W2, W1 and W0, advancing one state per cmd_valid byte; W0 returns to IDLE.
REQ-022 SHALL, in IDLE, discard any byte other than 0xA5; in the other states, treat every byte (including 0xA5) as data.
REQ-023 SHALL, on the W0 byte with channel < CHANNELS, write tw_shadow[channel], set pending, and pulse cmd_ack on the next cycle.
REQ-024 SHALL, on the W0 byte with channel >= CHANNELS, leave all state unchanged except the FSM, and pulse cmd_err on the next cycle.
REQ-025 SHALL, when a frame completes on a boundary cycle, apply the shadow at the next boundary, not the current one.
REQ-026 SHALL let a second frame to a channel with pending=1 overwrite tw_shadow, so only the last word is applied.
REQ-027 SHALL ignore cmd_data when cmd_valid=0; there is no inter-byte timeout.

Reset
REQ-028 SHALL, on rst=1, asynchronously clear cnt, all acc, tw_active, tw_shadow and pending.
REQ-029 SHALL, on rst=1, set all duty to LUT[0], pwm_out to 0, cmd_ack and cmd_err to 0, and the FSM to IDLE.
REQ-030 SHALL, after rst deasserts with enable=1, produce pwm_out at 50% duty (128/256 at defaults) on every channel.
REQ-031 SHALL, on reset mid-frame, discard the partial frame.

Verification
REQ-032 SHALL verify the no-command case: reset, then enable=1 with no commands -> each channel high for exactly 128 of every 256 cycles.
REQ-033 SHALL verify a quarter-step word: frame A5 00 40 00 00 -> cmd_ack, then channel 0 duty sequence 128, 255, 128, 1, repeating; channel 1 stays at 128.
REQ-034 SHALL verify channel rejection: frame A5 05 12 34 56 with CHANNELS=2 -> cmd_err pulse and no change to any tw_shadow.
REQ-035 SHALL verify resync and overwrite: garbage bytes 00 FF then A5 01 00 00 10, followed before the boundary by A5 01 00 00 20 -> two cmd_ack pulses, and only 0x000020 is applied.
REQ-036 SHALL verify hold: enable=0 for 1000 cycles mid-period -> pwm_out is 0, and cnt and acc resume unchanged afterwards.
REQ-037 SHALL verify mid-frame reset: rst pulsed after byte W2 -> parser returns to IDLE, and the next full frame is accepted normally.
